// File: rtl/md_unit_ctrl_pkg.sv
// md_unit_ctrl_pkg
//   Shared definitions for the multiply/divide controller: EX-stage op
//   encodings, FSM state encodings and small op-class helpers.
package md_unit_ctrl_pkg;

  // EX-stage mult/div op encoding; 7 is reserved and behaves like MD_NONE.
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Ops that occupy the unit for a busy period.
  function automatic logic md_is_muldiv(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_mult(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_result_calc.sv
// md_result_calc
//   Combinational HI/LO result for mult/multu/div/divu.
//   Ports:
//     i_op        3   op encoding (md_op_e)
//     i_a, i_b    32  operands (rs, rt)
//     o_hi, o_lo  32  result halves (0 for non-arithmetic ops)
//     o_div_zero  1   div/divu with zero divisor; result must be discarded
module md_result_calc
  import md_unit_ctrl_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_div_zero
);

  md_op_e             w_op;
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic        [31:0] w_abs_a;
  logic        [31:0] w_abs_b;
  logic        [31:0] w_dvd;
  logic        [31:0] w_dvs;
  logic        [31:0] w_quo;
  logic        [31:0] w_rem;

  assign w_op = md_op_e'(i_op);

  assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide runs on magnitudes; |0x80000000| fits in 32 unsigned bits,
  // so 0x80000000 / -1 falls out as 0x80000000 after negation without a
  // special case.
  assign w_abs_a = i_a[31] ? (~i_a + 32'd1) : i_a;
  assign w_abs_b = i_b[31] ? (~i_b + 32'd1) : i_b;

  // One shared unsigned divider; a zero divisor is replaced by 1 so the
  // datapath never produces X, the result is discarded via o_div_zero.
  always_comb begin
    w_dvd = i_a;
    w_dvs = i_b;
    if (w_op == MD_DIV) begin
      w_dvd = w_abs_a;
      w_dvs = w_abs_b;
    end
    if (w_dvs == 32'd0) begin
      w_dvs = 32'd1;
    end
  end

  assign w_quo = w_dvd / w_dvs;
  assign w_rem = w_dvd % w_dvs;

  always_comb begin
    o_hi       = 32'd0;
    o_lo       = 32'd0;
    o_div_zero = 1'b0;
    case (w_op)
      MD_MULT:  {o_hi, o_lo} = w_prod_s;
      MD_MULTU: {o_hi, o_lo} = w_prod_u;
      MD_DIV: begin
        o_div_zero = (i_b == 32'd0);
        // Quotient truncates toward zero; remainder takes the dividend's sign.
        o_lo = (i_a[31] ^ i_b[31]) ? (~w_quo + 32'd1) : w_quo;
        o_hi = i_a[31] ? (~w_rem + 32'd1) : w_rem;
      end
      MD_DIVU: begin
        o_div_zero = (i_b == 32'd0);
        o_lo       = w_quo;
        o_hi       = w_rem;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl
//   EX-stage multiply/divide controller. Starts mult/multu/div/divu, runs a
//   fixed busy period, owns the architectural HI/LO registers and asks the
//   hazard unit to stall ID when a mult/div-class instruction would collide
//   with the busy period.
//   Ports:
//     clk          1   clock, rising edge
//     reset        1   asynchronous reset, active-high
//     mdOp_Ex      3   EX op (md_op_e)
//     mdValid_Ex   1   EX slot holds a real instruction
//     srcA_Ex      32  forwarded rs
//     srcB_Ex      32  forwarded rt
//     ifMdUse_Id   1   ID instruction touches the mult/div unit or HI/LO
//     hi_Ex        32  architectural HI
//     lo_Ex        32  architectural LO
//     busy         1   operation in flight
//     stallReq_Hz  1   stall request to the hazard unit
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mdOp_Ex,
  input  logic        mdValid_Ex,
  input  logic [31:0] srcA_Ex,
  input  logic [31:0] srcB_Ex,
  input  logic        ifMdUse_Id,
  output logic [31:0] hi_Ex,
  output logic [31:0] lo_Ex,
  output logic        busy,
  output logic        stallReq_Hz
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_state_e         r_state;
  md_state_e         w_state_nxt;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_nxt;
  logic [31:0]       r_hi;
  logic [31:0]       w_hi_nxt;
  logic [31:0]       r_lo;
  logic [31:0]       w_lo_nxt;
  logic [31:0]       r_pend_hi;
  logic [31:0]       w_pend_hi_nxt;
  logic [31:0]       r_pend_lo;
  logic [31:0]       w_pend_lo_nxt;
  logic              r_pend_skip;
  logic              w_pend_skip_nxt;

  md_op_e            w_op;
  logic              w_start;
  logic [31:0]       w_calc_hi;
  logic [31:0]       w_calc_lo;
  logic              w_div_zero;

  md_result_calc u_result_calc (
    .i_op       (mdOp_Ex),
    .i_a        (srcA_Ex),
    .i_b        (srcB_Ex),
    .o_hi       (w_calc_hi),
    .o_lo       (w_calc_lo),
    .o_div_zero (w_div_zero)
  );

  assign w_op    = md_op_e'(mdOp_Ex);
  assign w_start = mdValid_Ex && md_is_muldiv(w_op) && (r_state == MD_IDLE);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hi_nxt        = r_hi;
    w_lo_nxt        = r_lo;
    w_pend_hi_nxt   = r_pend_hi;
    w_pend_lo_nxt   = r_pend_lo;
    w_pend_skip_nxt = r_pend_skip;

    case (r_state)
      MD_IDLE: begin
        if (w_start) begin
          w_state_nxt     = MD_BUSY;
          w_cnt_nxt       = md_is_mult(w_op) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
          w_pend_hi_nxt   = w_calc_hi;
          w_pend_lo_nxt   = w_calc_lo;
          w_pend_skip_nxt = w_div_zero;
        end else if (mdValid_Ex) begin
          if (w_op == MD_MTHI) w_hi_nxt = srcA_Ex;
          if (w_op == MD_MTLO) w_lo_nxt = srcA_Ex;
        end
      end
      MD_BUSY: begin
        // Any op arriving now (including mthi/mtlo) is dropped; the hazard
        // stall is what keeps dependent instructions out of EX.
        w_cnt_nxt = r_cnt - CntW'(1);
        if (r_cnt == CntW'(1)) begin
          w_state_nxt = MD_IDLE;
          if (!r_pend_skip) begin
            w_hi_nxt = r_pend_hi;
            w_lo_nxt = r_pend_lo;
          end
        end
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= MD_IDLE;
      r_cnt       <= '0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_pend_hi   <= 32'd0;
      r_pend_lo   <= 32'd0;
      r_pend_skip <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hi        <= w_hi_nxt;
      r_lo        <= w_lo_nxt;
      r_pend_hi   <= w_pend_hi_nxt;
      r_pend_lo   <= w_pend_lo_nxt;
      r_pend_skip <= w_pend_skip_nxt;
    end
  end

  assign hi_Ex       = r_hi;
  assign lo_Ex       = r_lo;
  assign busy        = (r_state == MD_BUSY);
  // Includes the start cycle, where busy is still low.
  assign stallReq_Hz = ifMdUse_Id && (busy || w_start);

endmodule
